// File: rtl/mem_stage_ctl_if.sv
// Pipeline-side request bundle and memory-target bus for mem_stage_ctl.
// The pipeline/testbench drives through master; the controller attaches as slave.
interface mem_stage_ctl_if;
    logic        mem_wen_in;
    logic        main_memory_enable_in;
    logic        frame_buffer_enable_in;
    logic        prog_mem_enable_in;
    logic        call_stack_enable_in;
    logic [15:0] addr_in;
    logic [7:0]  wdata_in;
    logic [13:0] call_addr_in;
    logic [7:0]  main_rdata;
    logic [7:0]  fb_rdata;
    logic [7:0]  prog_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        main_cs;
    logic        fb_cs;
    logic        prog_cs;
    logic        stall;
    logic [7:0]  rdata_out;
    logic        rdata_valid;
    logic [13:0] ret_addr_out;
    logic        ret_valid;
    logic        stack_overflow;
    logic        stack_underflow;
    logic        multi_sel_err;
    logic [15:0] stall_count;

    modport master (
        output mem_wen_in, main_memory_enable_in, frame_buffer_enable_in,
               prog_mem_enable_in, call_stack_enable_in, addr_in, wdata_in,
               call_addr_in, main_rdata, fb_rdata, prog_rdata,
        input  mem_addr, mem_wdata, mem_we, main_cs, fb_cs, prog_cs, stall,
               rdata_out, rdata_valid, ret_addr_out, ret_valid,
               stack_overflow, stack_underflow, multi_sel_err, stall_count
    );

    modport slave (
        input  mem_wen_in, main_memory_enable_in, frame_buffer_enable_in,
               prog_mem_enable_in, call_stack_enable_in, addr_in, wdata_in,
               call_addr_in, main_rdata, fb_rdata, prog_rdata,
        output mem_addr, mem_wdata, mem_we, main_cs, fb_cs, prog_cs, stall,
               rdata_out, rdata_valid, ret_addr_out, ret_valid,
               stack_overflow, stack_underflow, multi_sel_err, stall_count
    );
endinterface

// File: rtl/mem_stage_ctl.sv
// Memory-stage access controller: target chip selects with wait states plus hardware call stack.
// Optional stall statistic counter built when MEM_STAGE_CTL_STATS_EN is defined.
//
// state   | meaning
// IDLE    | no access in flight; zero-wait and call-stack requests complete here
// WAIT    | multi-cycle access in flight; cnt counts down to the completion cycle
module mem_stage_ctl #(
    parameter int MAIN_WAIT = 2,
    parameter int FB_WAIT   = 0,
    parameter int PROG_WAIT = 1,
    parameter int CS_DEPTH  = 16
) (
    input logic           clock,
    input logic           reset,
    mem_stage_ctl_if.slave bus
);
    localparam int IDX_W = $clog2(CS_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [PTR_W-1:0] sp;
    logic [13:0]      stack_mem [CS_DEPTH];
    logic [7:0]       rdata_q;
    logic             rdata_valid_q;
    logic [13:0]      ret_addr_q;
    logic             ret_valid_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             multi_q;

    logic [3:0]       en_vec;
    logic             sel_stack, sel_main, sel_fb, sel_prog, req, multi;
    logic [3:0]       w_sel;
    logic [7:0]       rd_mux;
    logic             active, mem_access, start_wait, done, stall;
    logic             stack_push, stack_pop, full, empty;
    logic [PTR_W-1:0] sp_dec;

    assign en_vec    = {bus.call_stack_enable_in, bus.main_memory_enable_in,
                        bus.frame_buffer_enable_in, bus.prog_mem_enable_in};
    assign sel_stack = bus.call_stack_enable_in;
    assign sel_main  = bus.main_memory_enable_in & ~sel_stack;
    assign sel_fb    = bus.frame_buffer_enable_in & ~sel_stack & ~bus.main_memory_enable_in;
    assign sel_prog  = bus.prog_mem_enable_in & ~sel_stack & ~bus.main_memory_enable_in
                       & ~bus.frame_buffer_enable_in;
    assign req       = |en_vec;
    assign multi     = ($countones(en_vec) > 1);

    always_comb begin
        w_sel  = 4'd0;
        rd_mux = 8'd0;
        if (sel_main) begin
            w_sel  = 4'(MAIN_WAIT);
            rd_mux = bus.main_rdata;
        end else if (sel_fb) begin
            w_sel  = 4'(FB_WAIT);
            rd_mux = bus.fb_rdata;
        end else if (sel_prog) begin
            w_sel  = 4'(PROG_WAIT);
            rd_mux = bus.prog_rdata;
        end
    end

    // Upstream holds its request stable during WAIT, so the live inputs still name the target.
    assign active     = ~reset & ((state == ST_WAIT) | req);
    assign mem_access = active & ~sel_stack;
    assign start_wait = ~reset & (state == ST_IDLE) & req & ~sel_stack & (w_sel != 4'd0);
    assign done       = ~reset & (((state == ST_IDLE) & req & ~sel_stack & (w_sel == 4'd0))
                                  | ((state == ST_WAIT) & (cnt == 4'd0)));
    assign stall      = start_wait | (~reset & (state == ST_WAIT) & (cnt != 4'd0));

    assign stack_push = ~reset & (state == ST_IDLE) & sel_stack & bus.mem_wen_in;
    assign stack_pop  = ~reset & (state == ST_IDLE) & sel_stack & ~bus.mem_wen_in;
    assign full       = (sp == PTR_W'(CS_DEPTH));
    assign empty      = (sp == '0);
    assign sp_dec     = sp - PTR_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= 4'd0;
            sp            <= '0;
            rdata_q       <= 8'd0;
            rdata_valid_q <= 1'b0;
            ret_addr_q    <= 14'd0;
            ret_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            multi_q       <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            ret_valid_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_wait) begin
                        cnt   <= w_sel - 4'd1;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_IDLE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
            if (done && !bus.mem_wen_in) begin
                rdata_q       <= rd_mux;
                rdata_valid_q <= 1'b1;
            end
            if (multi) multi_q <= 1'b1;
            if (stack_push) begin
                if (full) overflow_q <= 1'b1;
                else      sp         <= sp + PTR_W'(1);
            end
            if (stack_pop) begin
                ret_valid_q <= 1'b1;
                if (empty) begin
                    ret_addr_q  <= 14'd0;
                    underflow_q <= 1'b1;
                end else begin
                    ret_addr_q <= stack_mem[sp_dec[IDX_W-1:0]];
                    sp         <= sp_dec;
                end
            end
        end
    end

    // Stack storage carries no reset; entries are only read below the pointer.
    always_ff @(posedge clock) begin
        if (stack_push && !full) stack_mem[sp[IDX_W-1:0]] <= bus.call_addr_in;
    end

    assign bus.main_cs         = mem_access & sel_main;
    assign bus.fb_cs           = mem_access & sel_fb;
    assign bus.prog_cs         = mem_access & sel_prog;
    assign bus.mem_addr        = mem_access ? bus.addr_in : 16'd0;
    assign bus.mem_wdata       = mem_access ? bus.wdata_in : 8'd0;
    assign bus.mem_we          = mem_access & bus.mem_wen_in;
    assign bus.stall           = stall;
    assign bus.rdata_out       = rdata_q;
    assign bus.rdata_valid     = rdata_valid_q;
    assign bus.ret_addr_out    = ret_addr_q;
    assign bus.ret_valid       = ret_valid_q;
    assign bus.stack_overflow  = overflow_q;
    assign bus.stack_underflow = underflow_q;
    assign bus.multi_sel_err   = multi_q;

`ifdef MEM_STAGE_CTL_STATS_EN
    logic [15:0] stall_cnt_q;
    always_ff @(posedge clock) begin
        if (reset)                                   stall_cnt_q <= 16'd0;
        else if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.stall_count = 16'd0;
`endif
endmodule

// File: tb/tb_mem_stage_ctl.sv
// Directed self-checking bench for mem_stage_ctl with default parameters.
module tb_mem_stage_ctl;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    mem_stage_ctl_if bus ();

    mem_stage_ctl #(
        .MAIN_WAIT(2), .FB_WAIT(0), .PROG_WAIT(1), .CS_DEPTH(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.mem_wen_in             = 1'b0;
        bus.main_memory_enable_in  = 1'b0;
        bus.frame_buffer_enable_in = 1'b0;
        bus.prog_mem_enable_in     = 1'b0;
        bus.call_stack_enable_in   = 1'b0;
        bus.addr_in                = 16'd0;
        bus.wdata_in               = 8'd0;
        bus.call_addr_in           = 14'd0;
    endtask

    task automatic chk_stall_count(input string tag, input logic [15:0] exp_en);
`ifdef MEM_STAGE_CTL_STATS_EN
        chk(tag, bus.stall_count, exp_en);
`else
        chk(tag, bus.stall_count, 16'd0);
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        bus.main_rdata = 8'd0;
        bus.fb_rdata   = 8'd0;
        bus.prog_rdata = 8'd0;
        reset = 1'b1;
        step();
        step();
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_rvalid", bus.rdata_valid, 1'b0);
        chk("rst_rdata", bus.rdata_out, 8'd0);
        chk("rst_retv", bus.ret_valid, 1'b0);
        chk("rst_flags", {bus.stack_overflow, bus.stack_underflow, bus.multi_sel_err}, 3'b000);
        chk("rst_cs", {bus.main_cs, bus.fb_cs, bus.prog_cs, bus.mem_we}, 4'b0000);
        chk("rst_scnt", bus.stall_count, 16'd0);
        reset = 1'b0;
        step();

        // Main read, two wait states
        bus.main_memory_enable_in = 1'b1;
        bus.addr_in    = 16'h0040;
        bus.main_rdata = 8'hA5;
        @(negedge clock);
        chk("mr_t0_stall", bus.stall, 1'b1);
        chk("mr_t0_cs", bus.main_cs, 1'b1);
        chk("mr_t0_addr", bus.mem_addr, 16'h0040);
        chk("mr_t0_we", bus.mem_we, 1'b0);
        step();
        @(negedge clock);
        chk("mr_t1_stall", bus.stall, 1'b1);
        chk("mr_t1_cs", bus.main_cs, 1'b1);
        chk("mr_t1_rv", bus.rdata_valid, 1'b0);
        step();
        @(negedge clock);
        chk("mr_t2_stall", bus.stall, 1'b0);
        chk("mr_t2_cs", bus.main_cs, 1'b1);
        chk("mr_t2_rv", bus.rdata_valid, 1'b0);
        step();
        idle();
        chk("mr_t3_rv", bus.rdata_valid, 1'b1);
        chk("mr_t3_rd", bus.rdata_out, 8'hA5);
        @(negedge clock);
        chk("mr_t3_cs", bus.main_cs, 1'b0);
        chk("mr_t3_addr", bus.mem_addr, 16'h0000);
        chk_stall_count("mr_scnt", 16'd2);
        step();
        chk("mr_t4_rv", bus.rdata_valid, 1'b0);
        chk("mr_t4_rd", bus.rdata_out, 8'hA5);

        // Program read, one wait state
        bus.prog_mem_enable_in = 1'b1;
        bus.addr_in    = 16'h0200;
        bus.prog_rdata = 8'h5A;
        @(negedge clock);
        chk("pr_t0_stall", bus.stall, 1'b1);
        chk("pr_t0_cs", bus.prog_cs, 1'b1);
        step();
        @(negedge clock);
        chk("pr_t1_stall", bus.stall, 1'b0);
        chk("pr_t1_cs", bus.prog_cs, 1'b1);
        step();
        idle();
        chk("pr_rv", bus.rdata_valid, 1'b1);
        chk("pr_rd", bus.rdata_out, 8'h5A);
        chk_stall_count("pr_scnt", 16'd3);
        step();

        // Frame buffer write, zero wait
        bus.frame_buffer_enable_in = 1'b1;
        bus.mem_wen_in = 1'b1;
        bus.addr_in    = 16'h1234;
        bus.wdata_in   = 8'h3C;
        @(negedge clock);
        chk("fw_cs", bus.fb_cs, 1'b1);
        chk("fw_we", bus.mem_we, 1'b1);
        chk("fw_stall", bus.stall, 1'b0);
        chk("fw_addr", bus.mem_addr, 16'h1234);
        chk("fw_wdata", bus.mem_wdata, 8'h3C);
        chk("fw_other_cs", {bus.main_cs, bus.prog_cs}, 2'b00);
        step();
        idle();
        chk("fw_rv", bus.rdata_valid, 1'b0);
        chk("fw_rd_hold", bus.rdata_out, 8'h5A);
        @(negedge clock);
        chk("fw_cs_off", {bus.fb_cs, bus.mem_we}, 2'b00);
        step();

        // Back-to-back zero-wait frame buffer reads
        bus.frame_buffer_enable_in = 1'b1;
        bus.addr_in  = 16'h0010;
        bus.fb_rdata = 8'h11;
        @(negedge clock);
        chk("b2b_stall0", bus.stall, 1'b0);
        step();
        bus.addr_in  = 16'h0011;
        bus.fb_rdata = 8'h22;
        chk("b2b_rv0", bus.rdata_valid, 1'b1);
        chk("b2b_rd0", bus.rdata_out, 8'h11);
        @(negedge clock);
        chk("b2b_stall1", bus.stall, 1'b0);
        chk("b2b_addr1", bus.mem_addr, 16'h0011);
        step();
        idle();
        chk("b2b_rv1", bus.rdata_valid, 1'b1);
        chk("b2b_rd1", bus.rdata_out, 8'h22);
        step();
        chk("b2b_rv2", bus.rdata_valid, 1'b0);

        // Call stack push/push/pop/pop
        bus.call_stack_enable_in = 1'b1;
        bus.mem_wen_in   = 1'b1;
        bus.call_addr_in = 14'h0123;
        @(negedge clock);
        chk("cs_push_stall", bus.stall, 1'b0);
        chk("cs_push_nocs", {bus.main_cs, bus.fb_cs, bus.prog_cs, bus.mem_we}, 4'b0000);
        step();
        bus.call_addr_in = 14'h0456;
        step();
        bus.mem_wen_in = 1'b0;
        step();
        chk("cs_pop0_v", bus.ret_valid, 1'b1);
        chk("cs_pop0_a", bus.ret_addr_out, 14'h0456);
        step();
        idle();
        chk("cs_pop1_v", bus.ret_valid, 1'b1);
        chk("cs_pop1_a", bus.ret_addr_out, 14'h0123);
        step();
        chk("cs_pop_done", bus.ret_valid, 1'b0);
        chk("cs_no_uflow", bus.stack_underflow, 1'b0);

        // Overflow: 17 pushes, then 17 pops
        for (int i = 0; i < 17; i++) begin
            bus.call_stack_enable_in = 1'b1;
            bus.mem_wen_in   = 1'b1;
            bus.call_addr_in = 14'(14'h0100 + i);
            step();
            chk($sformatf("ovf_push%0d", i), bus.stack_overflow, (i == 16) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 17; k++) begin
            bus.call_stack_enable_in = 1'b1;
            bus.mem_wen_in = 1'b0;
            step();
            chk($sformatf("pop%0d_v", k), bus.ret_valid, 1'b1);
            chk($sformatf("pop%0d_a", k), bus.ret_addr_out,
                (k < 16) ? 14'(14'h010F - k) : 14'h0000);
            chk($sformatf("pop%0d_uf", k), bus.stack_underflow, (k == 16) ? 1'b1 : 1'b0);
        end
        idle();
        step();
        chk("ovf_sticky", bus.stack_overflow, 1'b1);
        chk("uf_sticky", bus.stack_underflow, 1'b1);
        chk("ms_before", bus.multi_sel_err, 1'b0);

        // Main and frame buffer together: main wins
        bus.main_memory_enable_in  = 1'b1;
        bus.frame_buffer_enable_in = 1'b1;
        bus.main_rdata = 8'h77;
        bus.fb_rdata   = 8'hEE;
        @(negedge clock);
        chk("ms_main_cs", bus.main_cs, 1'b1);
        chk("ms_fb_cs", bus.fb_cs, 1'b0);
        chk("ms_stall", bus.stall, 1'b1);
        step();
        chk("ms_flag", bus.multi_sel_err, 1'b1);
        step();
        step();
        idle();
        chk("ms_rd", bus.rdata_out, 8'h77);
        step();
        step();
        chk("ms_flag_sticky", bus.multi_sel_err, 1'b1);

        // Reset in the middle of a main read
        bus.main_memory_enable_in = 1'b1;
        bus.addr_in    = 16'h0040;
        bus.main_rdata = 8'hC3;
        step();
        reset = 1'b1;
        idle();
        step();
        @(negedge clock);
        chk("rw_stall", bus.stall, 1'b0);
        chk("rw_cs", bus.main_cs, 1'b0);
        chk("rw_rv", bus.rdata_valid, 1'b0);
        chk("rw_flags", {bus.stack_overflow, bus.stack_underflow, bus.multi_sel_err}, 3'b000);
        chk("rw_scnt", bus.stall_count, 16'd0);
        step();
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("rw_post%0d_rv", j), bus.rdata_valid, 1'b0);
            chk($sformatf("rw_post%0d_st", j), bus.stall, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctl.md
# mem_stage_ctl

Memory-stage access controller sitting directly downstream of the ID/EX and EX/MEM pipeline registers. It consumes the memory-enable, write-enable and call-address control fields carried down the pipe, drives chip selects for main memory, frame buffer and program memory with per-target wait states, and owns the hardware call stack. It back-pressures the upstream pipeline with `stall` while a multi-cycle access is in flight.

## Interface
Parameters:
- MAIN_WAIT, 2, wait-state cycles for main memory (0..15)
- FB_WAIT, 0, wait-state cycles for frame buffer (0..15)
- PROG_WAIT, 1, wait-state cycles for program memory (0..15)
- CS_DEPTH, 16, call-stack entries (power of two, 2..64)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mem_wen_in  in  1  write (1) / read (0) for the selected target
- main_memory_enable_in, frame_buffer_enable_in, prog_mem_enable_in, call_stack_enable_in  in  1 each  target request enables
- addr_in  in  16  access address; wdata_in  in  8  write data
- call_addr_in  in  14  return address to push
- main_rdata, fb_rdata, prog_rdata  in  8 each  target read data, valid on the completion cycle
- mem_addr  out  16; mem_wdata  out  8; mem_we  out  1; main_cs, fb_cs, prog_cs  out  1 each
- stall  out  1  freeze upstream pipeline registers
- rdata_out  out  8; rdata_valid  out  1
- ret_addr_out  out  14; ret_valid  out  1
- stack_overflow, stack_underflow, multi_sel_err  out  1 each  sticky error flags
- stall_count  out  16  stall-cycle statistic (see Configuration)

## Operation
- Request present when any enable is high. Priority when several high: call stack > main > frame buffer > program; multi_sel_err set (sticky).
- FSM states IDLE, WAIT. IDLE + request to target with W>0: load counter with W-1, go WAIT, stall=1. WAIT: stall=1, decrement; at counter 0 (completion cycle) stall=0, capture read data, return IDLE. W=0 targets complete in the request cycle with no stall.
- Chip select, mem_addr, mem_wdata, mem_we driven combinationally from inputs for every cycle of the access (request cycle through completion); all low/zero otherwise.
- Upstream holds request inputs stable while stall=1; upstream advances on the edge ending the completion cycle, so the next request is seen the following cycle (no retrigger).
- Reads: rdata_out/rdata_valid registered at end of completion cycle; rdata_valid pulses one cycle; rdata_out holds until next read. Writes never assert rdata_valid.
- Call stack (zero wait): mem_wen=1 push call_addr_in; mem_wen=0 pop, ret_addr_out/ret_valid next cycle (one-cycle pulse). Pointer width log2(CS_DEPTH)+1.
- Push when full: dropped, pointer unchanged, stack_overflow set. Pop when empty: ret_addr_out=0, ret_valid=1, stack_underflow set.
- Sticky flags clear only on reset.

## Timing
- Reset: all outputs 0, state IDLE, stack pointer 0, flags 0, stack contents undefined. Reset during WAIT aborts the access; stall=0 in the cycle after the reset edge.
- Request in cycle T, W wait states: stall high T..T+W-1, low at T+W; rdata_valid high in T+W+1.
- W=0: no stall, rdata_valid/ret_valid high in T+1.
- Back-to-back zero-wait requests: one per cycle, full throughput.

## Configuration
- MEM_STAGE_CTL_STATS_EN defined: stall_count increments every cycle stall=1, saturates at 16'hFFFF, cleared by reset.
- Undefined: counter not built; stall_count tied to 0.

## Test plan
- Main read, MAIN_WAIT=2, addr 16'h0040, main_rdata=8'hA5 -> stall high 2 cycles, main_cs high 3 cycles, rdata_out=8'hA5 with rdata_valid one cycle later.
- Frame-buffer write, FB_WAIT=0, addr 16'h1234, data 8'h3C -> fb_cs, mem_we high one cycle, no stall, no rdata_valid.
- Push 14'h0123 then 14'h0456, pop twice -> ret_addr_out 14'h0456 then 14'h0123, ret_valid pulses each.
- 17 pushes with CS_DEPTH=16 -> stack_overflow=1 after 17th; then 17 pops -> 16 valid values, 17th returns 0 with stack_underflow=1.
- Main and frame-buffer enables both high -> only main_cs asserted, multi_sel_err=1 and stays 1 until reset.
- Reset asserted mid-WAIT of main read -> stall 0, main_cs 0, rdata_valid never pulses; with MEM_STAGE_CTL_STATS_EN stall_count reads 0.
